onchip_memory_dp: RTL and testbench
===================================

ONCHIP_MEMORY_DP -- requirements
Module: onchip_memory_dp

Interface
REQ-001 Parameters SHALL be: DATA_W 32 (word width, multiple of 8); ADDR_W 17 (word-address width); DEPTH 100000 (words, <= 2^ADDR_W); READ_LATENCY 1 (1 or 2 cycles); INIT_FILE "onchip_memory_dp.hex" (initial contents).
REQ-002 One clock; reset is asynchronous and active-low: clk  in  1  sole clock; reset_n  in  1  async active-low reset.
REQ-003 clken  in  1  global clock enable; freeze  in  1  blocks new accesses.
REQ-004 s1_address  in  ADDR_W  word address; s1_byteenable  in  DATA_W/8  byte lanes; s1_chipselect  in  1  select; s1_read  in  1  read strobe; s1_write  in  1  write strobe; s1_writedata  in  DATA_W  write data.
REQ-005 s1_readdata  out  DATA_W  read data; s1_readdatavalid  out  1  one-cycle read-data qualifier.
REQ-006 Port s2 SHALL have the identical signal set, prefix s2_.

Function
REQ-007 An access SHALL be accepted on a port when chipselect & clken & ~freeze; read and write both high in one cycle SHALL be treated as write only.
REQ-008 Accepted write SHALL update only byte lanes with byteenable=1 at the next clk edge; byteenable=0 lanes unchanged.
REQ-009 Accepted read SHALL produce readdatavalid=1 with data exactly READ_LATENCY enabled cycles after acceptance; back-to-back reads SHALL give one valid pulse per read, in order, full throughput.
REQ-010 Same-port read of an address written in the same cycle: not applicable (write wins, REQ-007); a read accepted the cycle after a write SHALL return the new data.
REQ-011 Mixed-port read-during-write to same address SHALL return OLD data.
REQ-012 Both ports writing same address same cycle: per byte, s1 lane wins where both enabled; lanes enabled by one port only take that port's data.
REQ-013 Address >= DEPTH: write ignored; read accepted, returns all-zero data with normal readdatavalid.
REQ-014 clken=0 SHALL stall: memory, data and valid pipeline registers hold; readdatavalid forced 0; held valid presented on first cycle clken returns to 1 (no loss, no duplication).
REQ-015 freeze=1 SHALL block new accesses only; in-flight reads complete normally.
REQ-016 readdata SHALL hold its last valid value while readdatavalid=0.

Reset
REQ-017 reset_n=0 SHALL asynchronously clear all readdatavalid/pipeline valid bits and readdata registers to 0; in-flight reads are discarded (no valid after release).
REQ-018 Memory contents SHALL NOT be reset; they load from INIT_FILE at configuration only.
REQ-019 First access SHALL be accepted on the first clk edge with reset_n=1 sampled high.

Structure
REQ-020 Package onchip_memory_pkg SHALL hold READ_LATENCY legal values, byte-lane count function (DATA_W/8) and the out-of-range-read constant (zero).
REQ-021 Read valid/data pipeline SHALL be a sub-module onchip_memory_rdpipe, instantiated once per port, depth = READ_LATENCY.
REQ-022 Storage SHALL be inferable true-dual-port block RAM with byte enables; collision and range logic outside the array.

Verification
REQ-023 Write 0xDEADBEEF addr 5 via s1, be=0xF; read addr 5 via s2 -> s2_readdatavalid exactly READ_LATENCY cycles later, data 0xDEADBEEF.
REQ-024 Addr 7 holds 0x11223344; s1 write 0xAABBCCDD be=0x5 -> subsequent read 0x11BB33DD.
REQ-025 Same cycle s1 write 0xAAAAAAAA be=0x3, s2 write 0x55555555 be=0xF, addr 9 -> read 0x5555AAAA; same-cycle s2 read of addr 9 during s1 write returns prior contents.
REQ-026 Four back-to-back s1 reads addr 0..3, clken low 2 cycles mid-stream -> exactly four valid pulses, in order, none while clken=0.
REQ-027 Read addr DEPTH -> valid with 0x00000000; write addr DEPTH then read addr 0 -> addr 0 unchanged.
REQ-028 reset_n pulsed low with two reads in flight -> no readdatavalid after release, readdata=0, memory contents preserved.

Source files
------------

// File: rtl/onchip_memory_pkg.sv
// Shared constants and helpers for the dual-port on-chip memory.
package onchip_memory_pkg;
  localparam int         RL_MIN   = 1;
  localparam int         RL_MAX   = 2;
  localparam logic [7:0] OOR_BYTE = 8'h00;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit rl_legal(input int rl);
    return (rl >= RL_MIN) && (rl <= RL_MAX);
  endfunction
endpackage

// File: rtl/onchip_memory_dp_if.sv
// One memory-mapped slave port: request strobes plus read response.
interface onchip_memory_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_memory_rdpipe.sv
// Read-response pipeline for one port: valid shift register plus data stage.
module onchip_memory_rdpipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);
  logic [LAT:1] vld_q;
  logic [LAT:0] vld_pipe;

  assign vld_pipe = {vld_q, acc_i};

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  vld_q <= '0;
    else if (en_i) vld_q <= vld_pipe[LAT-1:0];

  // A stalled valid stays in the pipe but is only shown while enabled.
  assign vld_o = vld_pipe[LAT] & en_i;

  generate
    if (LAT == 1) begin : g_lat1
      // The RAM output register already is the single data stage.
      assign data_o = data_i;
    end else begin : g_lat2
      logic [DATA_W-1:0] dat_q;
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)                dat_q <= '0;
        else if (en_i && vld_pipe[1]) dat_q <= data_i;
      assign data_o = dat_q;
    end
  endgenerate
endmodule

// File: rtl/onchip_memory_dp.sv
// True dual-port byte-enabled RAM with registered reads, s1-priority
// collisions and zero data for out-of-range reads.
module onchip_memory_dp
  import onchip_memory_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 17,
  parameter int    DEPTH        = 100000,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_memory_dp.hex"
) (
  input logic              clk,
  input logic              reset_n,
  input logic              clken,
  input logic              freeze,
  onchip_memory_dp_if.slave s1,
  onchip_memory_dp_if.slave s2
);
  localparam int NB = byte_lanes(DATA_W);
  localparam int RL = rl_legal(READ_LATENCY) ? READ_LATENCY : RL_MIN;

  logic [1:0]                  cs, rdreq, wrreq, acc, wr, rd, inr;
  logic [1:0][ADDR_W-1:0]      addr;
  logic [1:0][NB-1:0]          be, we;
  logic [1:0][DATA_W-1:0]      wdata, ram_q, rdata, pdata;
  logic [1:0]                  rdzero_q, pvld;
  logic [DATA_W-1:0]           mem_q [DEPTH];

  assign cs    = {s2.chipselect, s1.chipselect};
  assign rdreq = {s2.read,       s1.read};
  assign wrreq = {s2.write,      s1.write};
  assign addr  = {s2.address,    s1.address};
  assign be    = {s2.byteenable, s1.byteenable};
  assign wdata = {s2.writedata,  s1.writedata};

  // Write wins over read on the same port; range check gates writes only.
  always_comb begin
    acc = '0; wr = '0; rd = '0; inr = '0;
    for (int p = 0; p < 2; p++) begin
      acc[p] = cs[p] & clken & ~freeze;
      wr[p]  = acc[p] & wrreq[p];
      rd[p]  = acc[p] & rdreq[p] & ~wrreq[p];
      inr[p] = (32'(addr[p]) < 32'(DEPTH));
    end
  end

  // Same-address collision: s1 owns every lane it enables.
  always_comb begin
    we    = '0;
    we[0] = {NB{wr[0] & inr[0]}} & be[0];
    we[1] = {NB{wr[1] & inr[1]}} & be[1] & ~(we[0] & {NB{addr[0] == addr[1]}});
  end

  // Storage is not reset; reads see pre-edge contents (old data on collision).
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[0][b]) mem_q[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
      if (we[1][b]) mem_q[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
    end
    for (int p = 0; p < 2; p++)
      if (rd[p] && inr[p]) ram_q[p] <= mem_q[addr[p]];
  end

  // Zero flag resets high so readdata reads back zero out of reset.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdzero_q <= '1;
    else
      for (int p = 0; p < 2; p++)
        if (rd[p]) rdzero_q[p] <= ~inr[p];

  always_comb begin
    rdata = '0;
    for (int p = 0; p < 2; p++)
      rdata[p] = rdzero_q[p] ? {NB{OOR_BYTE}} : ram_q[p];
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      onchip_memory_rdpipe #(.DATA_W(DATA_W), .LAT(RL)) u_rdpipe (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (clken),
        .acc_i   (rd[p]),
        .data_i  (rdata[p]),
        .vld_o   (pvld[p]),
        .data_o  (pdata[p])
      );
    end
  endgenerate

  assign s1.readdata      = pdata[0];
  assign s1.readdatavalid = pvld[0];
  assign s2.readdata      = pdata[1];
  assign s2.readdatavalid = pvld[1];
endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench for onchip_memory_dp with READ_LATENCY = 1.
module tb_onchip_memory_dp;
  localparam int DW = 32;
  localparam int AW = 17;
  localparam int DEPTH = 100000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clken, freeze;
  int   n_cmp = 0;
  int   n_err = 0;

  onchip_memory_dp_if #(.DATA_W(DW), .ADDR_W(AW)) m1 ();
  onchip_memory_dp_if #(.DATA_W(DW), .ADDR_W(AW)) m2 ();

  onchip_memory_dp #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1),
    .INIT_FILE("onchip_memory_dp.hex")
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .freeze(freeze),
    .s1(m1), .s2(m2)
  );

  always #5 clk = ~clk;

  // Negedge monitor of port-1 valid pulses, used for the stall sequence.
  logic            mon_en = 1'b0;
  logic [DW-1:0]   mon_q[$];
  int              mon_bad = 0;
  always @(negedge clk)
    if (mon_en && m1.readdatavalid) begin
      mon_q.push_back(m1.readdata);
      if (!clken) mon_bad++;
    end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m1.chipselect = 0; m1.read = 0; m1.write = 0;
    m2.chipselect = 0; m2.read = 0; m2.write = 0;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    m1.chipselect = 1; m1.write = 1; m1.read = 0; m1.address = a; m1.writedata = d; m1.byteenable = be;
  endtask
  task automatic wr2(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    m2.chipselect = 1; m2.write = 1; m2.read = 0; m2.address = a; m2.writedata = d; m2.byteenable = be;
  endtask
  task automatic rd1(input logic [AW-1:0] a);
    m1.chipselect = 1; m1.write = 0; m1.read = 1; m1.address = a; m1.byteenable = 4'hF;
  endtask
  task automatic rd2(input logic [AW-1:0] a);
    m2.chipselect = 1; m2.write = 0; m2.read = 1; m2.address = a; m2.byteenable = 4'hF;
  endtask

  initial begin
    clken = 1; freeze = 0;
    m1.address = '0; m1.byteenable = '0; m1.writedata = '0;
    m2.address = '0; m2.byteenable = '0; m2.writedata = '0;
    idle();
    #1 reset_n = 0;
    tick(); tick();
    chk("rst_s1_vld", m1.readdatavalid, 0);
    chk("rst_s1_data", m1.readdata, 0);
    chk("rst_s2_vld", m2.readdatavalid, 0);
    chk("rst_s2_data", m2.readdata, 0);
    reset_n = 1;

    // Basic write then cross-port read.
    wr1(5, 32'hDEADBEEF, 4'hF); tick();
    idle(); rd2(5);
    chk("a5_pre_vld", m2.readdatavalid, 0);
    tick();
    chk("a5_vld", m2.readdatavalid, 1);
    chk("a5_data", m2.readdata, 32'hDEADBEEF);
    idle(); tick();
    chk("a5_vld_drop", m2.readdatavalid, 0);
    chk("a5_data_hold", m2.readdata, 32'hDEADBEEF);

    // Partial byte write.
    wr1(7, 32'h11223344, 4'hF); tick();
    wr1(7, 32'hAABBCCDD, 4'h5); tick();
    rd1(7); tick();
    chk("a7_vld", m1.readdatavalid, 1);
    chk("a7_merge", m1.readdata, 32'h11BB33DD);

    // Same-address write collision, then read-during-write across ports.
    wr1(9, 32'h01020304, 4'hF); tick();
    wr1(9, 32'hAAAAAAAA, 4'h3); wr2(9, 32'h55555555, 4'hF); tick();
    idle(); rd1(9); tick();
    chk("a9_collide", m1.readdata, 32'h5555AAAA);
    idle(); wr1(9, 32'h12345678, 4'hF); rd2(9); tick();
    chk("a9_rdw_vld", m2.readdatavalid, 1);
    chk("a9_rdw_old", m2.readdata, 32'h5555AAAA);
    idle(); rd2(9); tick();
    chk("a9_new", m2.readdata, 32'h12345678);

    // Freeze blocks new accesses but lets the in-flight read finish.
    idle(); rd1(5); tick();
    freeze = 1; wr1(5, 32'h0, 4'hF);
    chk("frz_inflight_vld", m1.readdatavalid, 1);
    chk("frz_inflight_data", m1.readdata, 32'hDEADBEEF);
    tick();
    chk("frz_blocked_vld", m1.readdatavalid, 0);
    freeze = 0; rd1(5); tick();
    chk("frz_no_write", m1.readdata, 32'hDEADBEEF);

    // Fill 0..3 for the stall stream.
    idle(); wr1(0, 32'h10000000, 4'hF); wr2(1, 32'h10000001, 4'hF); tick();
    wr1(2, 32'h10000002, 4'hF); wr2(3, 32'h10000003, 4'hF); tick();
    idle(); tick();

    // Back-to-back reads with a two-cycle clken gap.
    mon_en = 1;
    rd1(0); tick();
    rd1(1); tick();
    rd1(2); clken = 0; tick();
    chk("stall1_vld", m1.readdatavalid, 0);
    tick();
    chk("stall2_vld", m1.readdatavalid, 0);
    chk("stall2_hold", m1.readdata, 32'h10000001);
    clken = 1; tick();
    rd1(3); tick();
    idle(); tick(); tick();
    mon_en = 0;
    chk("stream_count", mon_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("stream_%0d", i), (i < mon_q.size()) ? mon_q[i] : 32'hXXXXXXXX, 32'h10000000 + i);
    chk("stream_no_stall_vld", mon_bad, 0);

    // Out-of-range read and write.
    rd1(DEPTH); tick();
    chk("oor_vld", m1.readdatavalid, 1);
    chk("oor_data", m1.readdata, 32'h0);
    wr1(DEPTH, 32'hFFFFFFFF, 4'hF); tick();
    rd1(0); tick();
    chk("oor_wr_ignored", m1.readdata, 32'h10000000);

    // Reset with reads in flight on both ports.
    idle(); rd1(5); rd2(7); tick();
    idle();
    #2 reset_n = 0; #1;
    chk("rstf_s1_vld", m1.readdatavalid, 0);
    chk("rstf_s1_data", m1.readdata, 0);
    chk("rstf_s2_vld", m2.readdatavalid, 0);
    chk("rstf_s2_data", m2.readdata, 0);
    tick();
    reset_n = 1;
    tick();
    chk("rstr_s1_vld", m1.readdatavalid, 0);
    chk("rstr_s2_vld", m2.readdatavalid, 0);
    chk("rstr_s1_data", m1.readdata, 0);
    rd1(5); rd2(7); tick();
    chk("keep_a5", m1.readdata, 32'hDEADBEEF);
    chk("keep_a7", m2.readdata, 32'h11BB33DD);
    idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
